// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : branch_pc_unit
// Desc   : PC register, branch/jump resolution, sticky trap, branch counters.
// Rev    : 1.0  initial release
// ============================================================================
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        trap_clr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] C_CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] C_CAUSE_ILLEGAL  = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_trap_pc;
    logic [31:0] r_br_count;
    logic [31:0] r_br_taken_count;
    logic        r_trap;
    logic [1:0]  r_trap_cause;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_target;
    logic [31:0] w_jalr_target;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_fault;
    logic [1:0]  w_fault_cause;
    logic        w_br_cond;
    logic        w_br_legal;
    logic        w_br_exec;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_target   = r_pc + imm;
    assign w_jalr_target = (rs1_val + imm) & ~32'h0000_0001;

    // Flags come from rs1-rs2, so the inverted conditions are plain negations
    always_comb begin
        w_br_cond  = 1'b0;
        w_br_legal = 1'b1;
        case (funct3)
            3'b000:  w_br_cond = br_eq;
            3'b001:  w_br_cond = ~br_eq;
            3'b100:  w_br_cond = br_lt;
            3'b101:  w_br_cond = ~br_lt;
            3'b110:  w_br_cond = br_ltu;
            3'b111:  w_br_cond = ~br_ltu;
            default: w_br_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_next_pc     = r_pc;
        w_taken       = 1'b0;
        w_fault       = 1'b0;
        w_fault_cause = 2'b00;
        w_br_exec     = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_pc   = RESET_PC;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (is_jalr) begin
                        if (w_jalr_target[1]) begin
                            w_fault       = 1'b1;
                            w_fault_cause = C_CAUSE_MISALIGN;
                        end else begin
                            w_taken   = 1'b1;
                            w_next_pc = w_jalr_target;
                        end
                    end else if (is_jal) begin
                        if (w_pc_target[1:0] != 2'b00) begin
                            w_fault       = 1'b1;
                            w_fault_cause = C_CAUSE_MISALIGN;
                        end else begin
                            w_taken   = 1'b1;
                            w_next_pc = w_pc_target;
                        end
                    end else if (is_branch) begin
                        if (!w_br_legal) begin
                            w_fault       = 1'b1;
                            w_fault_cause = C_CAUSE_ILLEGAL;
                        end else if (w_br_cond && (w_pc_target[1:0] != 2'b00)) begin
                            w_fault       = 1'b1;
                            w_fault_cause = C_CAUSE_MISALIGN;
                        end else begin
                            w_br_exec = 1'b1;
                            if (w_br_cond) begin
                                w_taken   = 1'b1;
                                w_next_pc = w_pc_target;
                            end else begin
                                w_next_pc = w_pc_plus4;
                            end
                        end
                    end else begin
                        w_next_pc = w_pc_plus4;
                    end
                    if (w_fault) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (trap_clr) begin
                    w_next_pc   = RESET_PC;
                    w_state_nxt = ST_BOOT;
                end
            end
            default: begin
                w_next_pc   = RESET_PC;
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_BOOT;
            r_pc             <= RESET_PC;
            r_trap           <= 1'b0;
            r_trap_cause     <= 2'b00;
            r_trap_pc        <= 32'd0;
            r_br_count       <= 32'd0;
            r_br_taken_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_next_pc;
            // Faulting PC and counters survive trap_clr for post-mortem inspection
            if (w_fault) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_fault_cause;
                r_trap_pc    <= r_pc;
            end else if ((r_state == ST_HALT) && trap_clr) begin
                r_trap       <= 1'b0;
                r_trap_cause <= 2'b00;
            end
            if (w_br_exec) begin
                r_br_count <= r_br_count + 32'd1;
                if (w_taken) begin
                    r_br_taken_count <= r_br_taken_count + 32'd1;
                end
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign pc_valid       = (r_state == ST_RUN);
    assign next_pc        = w_next_pc;
    assign taken          = w_taken;
    assign trap           = r_trap;
    assign trap_cause     = r_trap_cause;
    assign trap_pc        = r_trap_pc;
    assign br_count       = r_br_count;
    assign br_taken_count = r_br_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_pc_unit
// Desc   : Directed and random checks of branch_pc_unit against a program model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_pc_unit;

    localparam logic [31:0] RST = 32'h0000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;
    logic        br_ltu = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1_val = 32'd0;
    logic        trap_clr = 1'b0;

    logic [31:0] pc, pc_plus4, next_pc, trap_pc, br_count, br_taken_count;
    logic        pc_valid, taken, trap;
    logic [1:0]  trap_cause;

    branch_pc_unit #(.RESET_PC(RST)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .imm(imm), .rs1_val(rs1_val), .trap_clr(trap_clr),
        .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .next_pc(next_pc),
        .taken(taken), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .br_count(br_count), .br_taken_count(br_taken_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Program-level model: the two compared operands stand in for rs1/rs2
    logic [31:0] op_a = 32'd0, op_b = 32'd0;
    int          m_mode;
    logic [31:0] m_pc, m_tpc, m_bc, m_btc;
    logic        m_trap;
    logic [1:0]  m_cause;
    logic [31:0] e_next;
    logic        e_taken, e_fault, e_br;
    logic [1:0]  e_cause;

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        op_a   = a;
        op_b   = b;
        br_eq  = (a == b);
        br_lt  = ($signed(a) < $signed(b));
        br_ltu = (a < b);
    endtask

    task automatic idle();
        stall = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        funct3 = 3'd0; imm = 32'd0; rs1_val = 32'd0; trap_clr = 1'b0;
        set_ops(32'd0, 32'd1);
    endtask

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = RST; m_tpc = 32'd0; m_bc = 32'd0; m_btc = 32'd0;
        m_trap = 1'b0; m_cause = 2'b00;
    endtask

    task automatic predict();
        logic [31:0] tgt;
        logic        go;
        tgt = 32'd0; go = 1'b0;
        e_next = m_pc; e_taken = 1'b0; e_fault = 1'b0; e_cause = 2'b00; e_br = 1'b0;
        if (m_mode == M_BOOT) begin
            e_next = RST;
        end else if (m_mode == M_HALT) begin
            if (trap_clr) e_next = RST;
        end else if (!stall) begin
            e_next = m_pc + 32'd4;
            if (is_jalr) begin
                go = 1'b1; tgt = (rs1_val + imm) & 32'hFFFF_FFFE;
            end else if (is_jal) begin
                go = 1'b1; tgt = m_pc + imm;
            end else if (is_branch) begin
                tgt = m_pc + imm; e_br = 1'b1;
                case (funct3)
                    3'd0: go = (op_a == op_b);
                    3'd1: go = (op_a != op_b);
                    3'd4: go = ($signed(op_a) <  $signed(op_b));
                    3'd5: go = ($signed(op_a) >= $signed(op_b));
                    3'd6: go = (op_a <  op_b);
                    3'd7: go = (op_a >= op_b);
                    default: begin e_fault = 1'b1; e_cause = 2'b10; end
                endcase
            end
            if (go && (tgt % 4 != 0)) begin e_fault = 1'b1; e_cause = 2'b01; end
            if (e_fault) begin
                e_next = m_pc; e_br = 1'b0;
            end else if (go) begin
                e_taken = 1'b1; e_next = tgt;
            end
        end
    endtask

    task automatic commit();
        case (m_mode)
            M_BOOT: begin m_mode = M_RUN; m_pc = RST; end
            M_RUN: if (!stall) begin
                if (e_fault) begin
                    m_trap = 1'b1; m_cause = e_cause; m_tpc = m_pc; m_mode = M_HALT;
                end else begin
                    m_pc = e_next;
                    if (e_br) begin
                        m_bc = m_bc + 32'd1;
                        if (e_taken) m_btc = m_btc + 32'd1;
                    end
                end
            end
            default: if (trap_clr) begin
                m_mode = M_BOOT; m_pc = RST; m_trap = 1'b0; m_cause = 2'b00;
            end
        endcase
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic test_reset();
        if (pc !== RST || pc_valid !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
            errors++; $display("FAIL reset_regs: pc=%h v=%b t=%b c=%b", pc, pc_valid, trap, trap_cause);
        end
        checks++;
        if (trap_pc !== 32'd0 || br_count !== 32'd0 || br_taken_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts: tpc=%h bc=%h btc=%h exp 0", trap_pc, br_count, br_taken_count);
        end
        checks++;
        if (next_pc !== RST || taken !== 1'b0) begin
            errors++; $display("FAIL reset_comb: next_pc=%h taken=%b exp %h 0", next_pc, taken, RST);
        end
        checks++;
        rst_n = 1'b1;
        model_reset();
        #1;
        if (pc !== RST || pc_valid !== 1'b0) begin
            errors++; $display("FAIL boot: pc=%h v=%b exp %h 0", pc, pc_valid, RST);
        end
        checks++;
        tick();
        if (pc !== 32'h0 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL run_entry: pc=%h v=%b exp 0 1", pc, pc_valid);
        end
        checks++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (pc !== 32'(4 * i) || pc_valid !== 1'b1) begin
                errors++; $display("FAIL seq_pc: pc=%h v=%b exp %h 1", pc, pc_valid, 32'(4 * i));
            end
            checks++;
        end
    endtask

    task automatic test_branch();
        is_jal = 1'b1; imm = 32'h100 - m_pc;
        tick(); idle();
        is_branch = 1'b1; funct3 = 3'b000; imm = 32'h20; set_ops(32'd7, 32'd7);
        predict(); #1;
        if (next_pc !== 32'h120 || taken !== 1'b1) begin
            errors++; $display("FAIL beq_taken_comb: next_pc=%h taken=%b exp 120 1", next_pc, taken);
        end
        checks++;
        tick();
        if (pc !== 32'h120 || br_count !== 32'd1 || br_taken_count !== 32'd1) begin
            errors++; $display("FAIL beq_taken: pc=%h bc=%0d btc=%0d exp 120 1 1", pc, br_count, br_taken_count);
        end
        checks++;
        set_ops(32'd7, 32'd9);
        predict(); #1;
        if (next_pc !== 32'h124 || taken !== 1'b0) begin
            errors++; $display("FAIL beq_not_comb: next_pc=%h taken=%b exp 124 0", next_pc, taken);
        end
        checks++;
        tick();
        if (pc !== 32'h124 || br_count !== 32'd2 || br_taken_count !== 32'd1) begin
            errors++; $display("FAIL beq_not: pc=%h bc=%0d btc=%0d exp 124 2 1", pc, br_count, br_taken_count);
        end
        checks++;
        idle();
    endtask

    task automatic test_jalr();
        logic [31:0] fault_pc;
        is_jalr = 1'b1; rs1_val = 32'h203; imm = 32'h1;
        predict(); #1;
        if (next_pc !== 32'h204 || taken !== 1'b1) begin
            errors++; $display("FAIL jalr_comb: next_pc=%h taken=%b exp 204 1", next_pc, taken);
        end
        checks++;
        tick();
        if (pc !== 32'h204 || trap !== 1'b0) begin
            errors++; $display("FAIL jalr: pc=%h trap=%b exp 204 0", pc, trap);
        end
        checks++;
        fault_pc = pc;
        rs1_val = 32'h202; imm = 32'h0;
        predict(); #1;
        if (taken !== 1'b0 || next_pc !== fault_pc) begin
            errors++; $display("FAIL jalr_mis_comb: next_pc=%h taken=%b exp %h 0", next_pc, taken, fault_pc);
        end
        checks++;
        tick();
        if (trap !== 1'b1 || trap_cause !== 2'b01 || trap_pc !== fault_pc || pc !== fault_pc || pc_valid !== 1'b0) begin
            errors++; $display("FAIL jalr_mis: trap=%b c=%b tpc=%h pc=%h v=%b exp 1 01 %h %h 0",
                               trap, trap_cause, trap_pc, pc, pc_valid, fault_pc, fault_pc);
        end
        checks++;
        is_jal = 1'b1; imm = 32'h40;
        tick();
        if (pc !== fault_pc || pc_valid !== 1'b0 || trap !== 1'b1) begin
            errors++; $display("FAIL halt_frozen: pc=%h v=%b trap=%b exp %h 0 1", pc, pc_valid, trap, fault_pc);
        end
        checks++;
        idle(); trap_clr = 1'b1;
        tick(); idle(); tick();
        if (pc !== RST || pc_valid !== 1'b1 || trap !== 1'b0) begin
            errors++; $display("FAIL jalr_restart: pc=%h v=%b trap=%b exp 0 1 0", pc, pc_valid, trap);
        end
        checks++;
    endtask

    task automatic test_illegal();
        is_jal = 1'b1; imm = 32'h40 - m_pc;
        tick(); idle();
        is_branch = 1'b1; funct3 = 3'b010; set_ops(32'd1, 32'd1);
        tick(); idle();
        if (trap !== 1'b1 || trap_cause !== 2'b10 || trap_pc !== 32'h40 || br_count !== 32'd2) begin
            errors++; $display("FAIL illegal: trap=%b c=%b tpc=%h bc=%0d exp 1 10 40 2", trap, trap_cause, trap_pc, br_count);
        end
        checks++;
        trap_clr = 1'b1;
        tick(); trap_clr = 1'b0;
        if (pc !== RST || pc_valid !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'b00 || trap_pc !== 32'h40
            || br_count !== 32'd2 || br_taken_count !== 32'd1) begin
            errors++; $display("FAIL trap_clr: pc=%h v=%b t=%b c=%b tpc=%h bc=%0d btc=%0d",
                               pc, pc_valid, trap, trap_cause, trap_pc, br_count, br_taken_count);
        end
        checks++;
        tick();
        if (pc !== RST || pc_valid !== 1'b1) begin
            errors++; $display("FAIL clr_boot_len: pc=%h v=%b exp 0 1", pc, pc_valid);
        end
        checks++;
    endtask

    task automatic test_stall();
        logic [31:0] base;
        base = pc;
        stall = 1'b1; is_jal = 1'b1; imm = 32'h80;
        for (int i = 0; i < 3; i++) begin
            predict(); #1;
            if (taken !== 1'b0 || next_pc !== base) begin
                errors++; $display("FAIL stall_comb: next_pc=%h taken=%b exp %h 0", next_pc, taken, base);
            end
            checks++;
            tick();
            if (pc !== base || br_count !== m_bc) begin
                errors++; $display("FAIL stall_hold: pc=%h bc=%0d exp %h %0d", pc, br_count, base, m_bc);
            end
            checks++;
        end
        stall = 1'b0;
        tick();
        if (pc !== base + 32'h80) begin
            errors++; $display("FAIL stall_release: pc=%h exp %h", pc, base + 32'h80);
        end
        checks++;
        idle(); stall = 1'b1; is_branch = 1'b1; funct3 = 3'b011;
        tick(); idle();
        if (trap !== 1'b0 || pc_valid !== 1'b1 || pc !== base + 32'h80) begin
            errors++; $display("FAIL stall_beats_trap: trap=%b v=%b pc=%h", trap, pc_valid, pc);
        end
        checks++;
    endtask

    task automatic test_wrap();
        is_jal = 1'b1; imm = 32'hFFFF_FFFC - m_pc;
        tick(); idle();
        #1;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 || next_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_comb: pc=%h pc4=%h next=%h exp FFFFFFFC 0 0", pc, pc_plus4, next_pc);
        end
        checks++;
        tick();
        if (pc !== 32'h0) begin
            errors++; $display("FAIL wrap: pc=%h exp 0", pc);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        is_jal = 1'b1; imm = 32'h2;
        tick(); idle(); stall = 1'b1;
        if (trap !== 1'b1) begin
            errors++; $display("FAIL pre_reset_trap: trap=%b exp 1", trap);
        end
        checks++;
        #3 rst_n = 1'b0;
        #1;
        if (pc !== RST || pc_valid !== 1'b0 || trap !== 1'b0 || trap_cause !== 2'b00 || trap_pc !== 32'd0
            || br_count !== 32'd0 || br_taken_count !== 32'd0 || next_pc !== RST || taken !== 1'b0) begin
            errors++; $display("FAIL async_reset: pc=%h v=%b t=%b c=%b tpc=%h bc=%h btc=%h next=%h tk=%b",
                               pc, pc_valid, trap, trap_cause, trap_pc, br_count, br_taken_count, next_pc, taken);
        end
        checks++;
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(); tick();
        if (pc !== 32'h4 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset: pc=%h v=%b exp 4 1", pc, pc_valid);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 600; i++) begin
            stall     = ($urandom_range(0, 7) == 0);
            is_branch = ($urandom_range(0, 1) == 0);
            is_jal    = ($urandom_range(0, 4) == 0);
            is_jalr   = ($urandom_range(0, 4) == 0);
            funct3    = 3'($urandom_range(0, 7));
            imm       = $urandom_range(0, 5) == 0 ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            rs1_val   = $urandom_range(0, 5) == 0 ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            trap_clr  = ($urandom_range(0, 2) == 0);
            a = 32'($urandom);
            set_ops(a, $urandom_range(0, 3) == 0 ? a : 32'($urandom));
            predict(); #1;
            if (next_pc !== e_next || taken !== e_taken) begin
                errors++; $display("FAIL rand_comb[%0d]: next_pc=%h taken=%b exp %h %b", i, next_pc, taken, e_next, e_taken);
            end
            checks++;
            tick();
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || pc_valid !== (m_mode == M_RUN) || trap !== m_trap
                || trap_cause !== m_cause || trap_pc !== m_tpc || br_count !== m_bc || br_taken_count !== m_btc) begin
                errors++; $display("FAIL rand_state[%0d]: pc=%h v=%b t=%b c=%b tpc=%h bc=%0d btc=%0d exp %h %b %b %b %h %0d %0d",
                                   i, pc, pc_valid, trap, trap_cause, trap_pc, br_count, br_taken_count,
                                   m_pc, (m_mode == M_RUN), m_trap, m_cause, m_tpc, m_bc, m_btc);
            end
            checks++;
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        test_branch();
        test_jalr();
        test_illegal();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
